// File: rtl/uart_mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl_pkg
// Purpose  : Register offsets and window decode shared by the UART MMIO block
// Revision : 1.0 - initial release
// ============================================================================
package uart_mmio_ctrl_pkg;

  // Upper address nibble that selects the MMIO window
  localparam logic [3:0] MMIO_BASE_NIBBLE = 4'h8;

  // Register offsets within the window (addr[4:0])
  localparam logic [4:0] MMIO_RX_CTRL = 5'h00;
  localparam logic [4:0] MMIO_RX_DATA = 5'h04;
  localparam logic [4:0] MMIO_TX_CTRL = 5'h08;
  localparam logic [4:0] MMIO_TX_DATA = 5'h0C;
  localparam logic [4:0] MMIO_CYC     = 5'h10;
  localparam logic [4:0] MMIO_INST    = 5'h14;
  localparam logic [4:0] MMIO_CNT_RST = 5'h18;

  // True when a byte address falls inside the MMIO window
  function automatic logic mmio_hit(input logic [31:0] a);
    return (a[31:28] == MMIO_BASE_NIBBLE);
  endfunction

endpackage : uart_mmio_ctrl_pkg
`default_nettype wire

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy counter and show-ahead output
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Requests are masked here so a caller cannot corrupt the occupancy
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_ctrl
// Purpose  : CPU-facing MMIO window for UART RX/TX FIFOs and perf counters
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        inst_retire,
  output logic        hit,
  output logic [31:0] rdata,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  logic        w_acc, w_load, w_store;
  logic [4:0]  w_sel;
  logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [7:0]  w_rx_head;
  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic        w_tx_store, w_tx_drop, w_cnt_clr;
  logic [31:0] w_load_data;
  logic        r_drop;
  logic [31:0] r_cyc;
  logic [31:0] r_inst;
  logic [31:0] r_rdata;
  logic        w_unused;

  // Address bits between the window nibble and the offset are ignored
  assign w_unused = ^{addr[27:5], wdata[31:8]};

  assign hit     = mmio_hit(addr);
  assign w_acc   = en & hit & ~stall;
  assign w_load  = w_acc & ~we;
  assign w_store = w_acc & we;
  assign w_sel   = addr[4:0];

  // RX side: UART fills, CPU drains through RX-data loads
  assign uart_rx_ready = ~w_rx_full;
  assign w_rx_push     = uart_rx_valid & ~w_rx_full;
  assign w_rx_pop      = w_load & (w_sel == MMIO_RX_DATA) & ~w_rx_empty;

  // TX side: fullness is sampled before any same-cycle UART pop
  assign w_tx_store    = w_store & (w_sel == MMIO_TX_DATA);
  assign w_tx_push     = w_tx_store & ~w_tx_full;
  assign w_tx_drop     = w_tx_store & w_tx_full;
  assign w_tx_pop      = ~w_tx_empty & uart_tx_ready;
  assign uart_tx_valid = ~w_tx_empty;

  assign w_cnt_clr = w_store & (w_sel == MMIO_CNT_RST);
  assign rdata     = r_rdata;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (uart_rx_data),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .dout  (w_rx_head)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (wdata[7:0]),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .dout  (uart_tx_data)
  );

  // Read mux; an empty RX-data load returns 0 rather than a stale byte
  always_comb begin
    w_load_data = '0;
    case (w_sel)
      MMIO_RX_CTRL: w_load_data = {31'd0, ~w_rx_empty};
      MMIO_RX_DATA: w_load_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      MMIO_TX_CTRL: w_load_data = {30'd0, r_drop, ~w_tx_full};
      MMIO_CYC:     w_load_data = r_cyc;
      MMIO_INST:    w_load_data = r_inst;
      default:      w_load_data = '0;
    endcase
  end

  // Load data lands one cycle later to line up with dmem in writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_rdata <= '0;
    else if (w_load) r_rdata <= w_load_data;
  end

  // Sticky drop flag: a new drop beats the read-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_drop <= 1'b0;
    else if (w_tx_drop)                        r_drop <= 1'b1;
    else if (w_load && w_sel == MMIO_TX_CTRL)  r_drop <= 1'b0;
  end

  // Free-running counters; a clear store wins over the same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else if (w_cnt_clr) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (inst_retire && !stall) r_inst <= r_inst + 32'd1;
    end
  end

endmodule : uart_mmio_ctrl
`default_nettype wire
